// File: rtl/score_seg_scan.sv
// Score display stage: binary score -> BCD via a sequential double-dabble engine,
// then time-multiplexed onto a four-digit common-anode 7-segment display.
module score_seg_scan #(
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [13:0] score,
    input  logic        score_valid,
    output logic        busy,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  AN
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    localparam logic [13:0] SAT_MAX = 14'd9999;

    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [1:0]    state_r;
    logic [13:0]   sh_r;
    logic [15:0]   work_r;
    logic [3:0]    step_r;
    logic          busy_r;
    logic [15:0]   disp_r;
    logic          pend_r;
    logic [13:0]   pend_val_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;
    logic          dp_r;

    logic          start_s;
    logic [13:0]   start_val_s;
    logic [13:0]   sat_s;
    logic [15:0]   adj_s;
    logic [3:0]    digit_s;
    logic          lead_zero_s;
    logic          blank_s;
    logic [3:0]    an_sel_s;

    // Conversion start selection: a fresh strobe overrides an older pending score
    always_comb begin
        sat_s       = saturate(score);
        adj_s       = add3(work_r);
        start_s     = 1'b0;
        start_val_s = 14'd0;
        if (state_r == ST_IDLE) begin
            start_s     = score_valid | pend_r;
            start_val_s = score_valid ? sat_s : pend_val_r;
        end else begin
            start_s     = 1'b0;
            start_val_s = 14'd0;
        end
    end

    // Double-dabble FSM; display register only changes in LOAD so no torn value is shown
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
            sh_r    <= 14'd0;
            work_r  <= 16'd0;
            step_r  <= 4'd0;
            busy_r  <= 1'b0;
            disp_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        sh_r    <= start_val_s;
                        work_r  <= 16'd0;
                        step_r  <= 4'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_r <= {adj_s[14:0], sh_r[13]};
                    sh_r   <= {sh_r[12:0], 1'b0};
                    step_r <= step_r + 4'd1;
                    if (step_r == 4'd13) begin
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_LOAD: begin
                    disp_r  <= work_r;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Pending score capture for strobes arriving while a conversion (incl. LOAD) runs
    always_ff @(posedge clk) begin
        if (!clr) begin
            pend_r     <= 1'b0;
            pend_val_r <= 14'd0;
        end else if (score_valid && (state_r != ST_IDLE)) begin
            pend_r     <= 1'b1;
            pend_val_r <= sat_s;
        end else if (start_s) begin
            pend_r     <= 1'b0;
        end else begin
            pend_r     <= pend_r;
        end
    end

    // Free-running scan divider and digit index
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_r <= CNT_ZERO;
            idx_r <= 2'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Selected digit, leading-zero detection and anode pattern
    always_comb begin
        digit_s     = 4'd0;
        lead_zero_s = 1'b0;
        an_sel_s    = 4'b1111;
        case (idx_r)
            2'd0: begin
                digit_s     = disp_r[3:0];
                lead_zero_s = 1'b0;
                an_sel_s    = 4'b1110;
            end
            2'd1: begin
                digit_s     = disp_r[7:4];
                lead_zero_s = (disp_r[15:4] == 12'd0);
                an_sel_s    = 4'b1101;
            end
            2'd2: begin
                digit_s     = disp_r[11:8];
                lead_zero_s = (disp_r[15:8] == 8'd0);
                an_sel_s    = 4'b1011;
            end
            2'd3: begin
                digit_s     = disp_r[15:12];
                lead_zero_s = (disp_r[15:12] == 4'd0);
                an_sel_s    = 4'b0111;
            end
            default: begin
                digit_s     = 4'd0;
                lead_zero_s = 1'b0;
                an_sel_s    = 4'b1111;
            end
        endcase
        blank_s = (BLANK_LZ != 0) && lead_zero_s;
    end

    // Registered display drive
    always_ff @(posedge clk) begin
        if (!clr) begin
            seg_r <= 7'b1111111;
            an_r  <= 4'b1111;
            dp_r  <= 1'b1;
        end else if (blank_s) begin
            seg_r <= 7'b1111111;
            an_r  <= 4'b1111;
            dp_r  <= 1'b1;
        end else begin
            seg_r <= decode(digit_s);
            an_r  <= an_sel_s;
            dp_r  <= 1'b1;
        end
    end

    assign busy = busy_r;
    assign seg  = seg_r;
    assign dp   = dp_r;
    assign AN   = an_r;

endmodule

// File: tb/tb_score_seg_scan.sv
// Bench for score_seg_scan: two instances (leading-zero blanking on/off) checked
// against a decimal-arithmetic model of the displayed digits and conversion timing.
module tb_score_seg_scan;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [13:0] score = 14'd0;
    logic        score_valid = 1'b0;

    logic        busy1, dp1, busy0, dp0;
    logic [6:0]  seg1, seg0;
    logic [3:0]  an1, an0;

    int n_vec = 0;
    int n_err = 0;
    int k = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    score_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(1)) dut_lz (
        .clk(clk), .clr(clr), .score(score), .score_valid(score_valid),
        .busy(busy1), .seg(seg1), .dp(dp1), .AN(an1)
    );

    score_seg_scan #(.SCAN_DIV(SD), .BLANK_LZ(0)) dut_all (
        .clk(clk), .clr(clr), .score(score), .score_valid(score_valid),
        .busy(busy0), .seg(seg0), .dp(dp0), .AN(an0)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; the scan slot on display follows from this
    always @(posedge clk) begin
        if (!clr) k <= 0;
        else      k <= k + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int s);
        case (s)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 1000;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int s, input bit blank);
        if (blank && s > 0 && sat(v) < pow10(s)) return 7'b1111111;
        return seg_tab[(sat(v) / pow10(s)) % 10];
    endfunction

    function automatic logic [3:0] exp_an(input int v, input int s, input bit blank);
        logic [3:0] a;
        a = 4'b1111;
        if (blank && s > 0 && sat(v) < pow10(s)) return a;
        a[s] = 1'b0;
        return a;
    endfunction

    // Compare the current display of both instances against decimal value v
    task automatic cmp_out(input int v);
        int s;
        if (k == 0) begin
            chk("rst_an", 16'({an1, an0}), 16'h00ff);
            chk("rst_seg", 16'({seg1, seg0}), 16'h3fff);
        end else begin
            s = ((k - 1) / SD) % 4;
            chk($sformatf("an_lz v=%0d slot=%0d", v, s), 16'(an1), 16'(exp_an(v, s, 1'b1)));
            chk($sformatf("seg_lz v=%0d slot=%0d", v, s), 16'(seg1), 16'(exp_seg(v, s, 1'b1)));
            chk($sformatf("an_all v=%0d slot=%0d", v, s), 16'(an0), 16'(exp_an(v, s, 1'b0)));
            chk($sformatf("seg_all v=%0d slot=%0d", v, s), 16'(seg0), 16'(exp_seg(v, s, 1'b0)));
        end
        chk("dp", 16'({dp1, dp0}), 16'h0003);
    endtask

    task automatic scan(input int v, input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_out(v);
        end
    endtask

    task automatic chk_busy(input string tag, input bit exp);
        chk(tag, 16'({busy1, busy0}), exp ? 16'h0003 : 16'h0000);
    endtask

    // Single conversion: busy for cycles N+1..N+15, new value on the display after that
    task automatic convert(input int v);
        score       = 14'(v);
        score_valid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) score_valid = 1'b0;
            chk_busy($sformatf("busy v=%0d c=%0d", v, c), c <= 15);
        end
        scan(v, 16);
    endtask

    // Back-to-back strobes: later ones (while busy) become one pending conversion
    task automatic overlap(input int v1, input int v2, input int g, input int v3);
        int vf;
        vf = (v3 >= 0) ? v3 : v2;
        score       = 14'(v1);
        score_valid = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            chk_busy($sformatf("ovl_busy c=%0d", c), (c <= 15) || (c >= 17 && c <= 31));
            if (c >= 17 && c <= 28) cmp_out(v1);
            if (c == 1) score_valid = 1'b0;
            if (c == g) begin
                score       = 14'(v2);
                score_valid = 1'b1;
            end else if (c == g + 1 || c == g + 3) begin
                score_valid = 1'b0;
            end else if (c == g + 2 && v3 >= 0) begin
                score       = 14'(v3);
                score_valid = 1'b1;
            end
        end
        scan(vf, 16);
    endtask

    initial begin
        int v;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_busy("rst_busy", 1'b0);
        cmp_out(0);
        clr = 1'b1;
        scan(0, 16);

        convert(1234);
        convert(12345);
        convert(7);
        convert(0);
        convert(9999);
        convert(10000);
        convert(16383);
        convert(1000);
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 16383));
            convert(v);
        end

        overlap(42, 905, 5, -1);
        overlap(int'($urandom_range(0, 9999)), int'($urandom_range(0, 16383)), 15, -1);
        overlap(321, 654, 3, 87);
        for (int i = 0; i < 3; i++) begin
            overlap(int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)),
                    int'($urandom_range(2, 12)), int'($urandom_range(0, 9999)));
        end

        // Reset in SHIFT step 7 of 8888 with 1111 pending: both discarded
        score       = 14'd8888;
        score_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) score_valid = 1'b0;
            if (c == 3) begin
                score       = 14'd1111;
                score_valid = 1'b1;
            end
            if (c == 4) score_valid = 1'b0;
            if (c == 7) clr = 1'b0;
        end
        chk_busy("midrst_busy", 1'b0);
        cmp_out(0);
        clr = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk_busy($sformatf("post_rst_busy c=%0d", c), 1'b0);
            cmp_out(0);
        end

        convert(int'($urandom_range(0, 16383)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
